// File: rtl/ddr_channel_responder.sv
// ---------------------------------------------------------------------------
// ddr_channel_responder
//
// Far-end responder for one pod's DDR channel. Holds a local backing store,
// commits writes, and answers reads with a fixed pipelined latency of RD_LAT
// cycles. Also keeps saturating request counters and a sticky out-of-range
// flag. Used in place of a real DDR controller for simulation and FPGA
// bring-up.
//
// Ports:
//   clk, rst        - clock (rising edge), asynchronous active-high reset
//   ce              - clock enable; 0 freezes every register
//   r_valid, r_addr - read request strobe / word address
//   r_data          - read response data (last pipeline stage)
//   r_data_valid    - one-cycle strobe per accepted read
//   w_valid, w_addr - write request strobe / word address
//   w_data          - write data
//   busy            - at least one read is in flight
//   rd_count        - accepted reads, saturating at 0xFFFF_FFFF
//   wr_count        - accepted writes (including out-of-range), saturating
//   oob_err         - sticky out-of-range access flag, cleared by rst only
// ---------------------------------------------------------------------------
module ddr_channel_responder #(
   parameter int unsigned ADDR_W     = 14,
   parameter int unsigned OFFCHIP_DW = 512,
   parameter int unsigned DEPTH_W    = 10,
   parameter int unsigned RD_LAT     = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ce,
   input  logic                  r_valid,
   input  logic [ADDR_W-1:0]     r_addr,
   output logic [OFFCHIP_DW-1:0] r_data,
   output logic                  r_data_valid,
   input  logic                  w_valid,
   input  logic [ADDR_W-1:0]     w_addr,
   input  logic [OFFCHIP_DW-1:0] w_data,
   output logic                  busy,
   output logic [31:0]           rd_count,
   output logic [31:0]           wr_count,
   output logic                  oob_err
);

   localparam int unsigned DEPTH = 2 ** DEPTH_W;
   localparam int unsigned CNT_W = 32;

   // Backing store; deliberately not reset so contents survive rst.
   logic [OFFCHIP_DW-1:0] mem [DEPTH];

   logic                  rd_acc;
   logic                  wr_acc;
   logic                  rd_in_range;
   logic                  wr_in_range;
   logic [DEPTH_W-1:0]    rd_idx;
   logic [DEPTH_W-1:0]    wr_idx;
   logic [OFFCHIP_DW-1:0] rd_word;

   // Read pipeline: stage 0 captures the request, stage RD_LAT-1 is the output.
   logic [RD_LAT-1:0]     pipe_valid;
   logic [RD_LAT-1:0]     pipe_valid_nxt;
   logic [OFFCHIP_DW-1:0] pipe_data [RD_LAT];

   // Request acceptance; rst is included so the unreset store is never
   // written while reset is held.
   assign rd_acc = ce & r_valid & ~rst;
   assign wr_acc = ce & w_valid & ~rst;

   // An address is in range when every bit above the index field is zero.
   assign rd_in_range = ((r_addr >> DEPTH_W) == '0);
   assign wr_in_range = ((w_addr >> DEPTH_W) == '0);
   assign rd_idx      = r_addr[DEPTH_W-1:0];
   assign wr_idx      = w_addr[DEPTH_W-1:0];

   // Read word selection: out-of-range reads return zero, and a same-edge
   // write to the same index is forwarded so the read sees the new data.
   always_comb begin
      rd_word = '0;
      if (rd_in_range) begin
         if (wr_acc && wr_in_range && (wr_idx == rd_idx)) begin
            rd_word = w_data;
         end else begin
            rd_word = mem[rd_idx];
         end
      end
   end

   // Next stage-valid vector: shift toward the output, new request enters stage 0.
   always_comb begin
      pipe_valid_nxt = '0;
      for (int i = int'(RD_LAT) - 1; i > 0; i--) begin
         pipe_valid_nxt[i] = pipe_valid[i-1];
      end
      pipe_valid_nxt[0] = rd_acc;
   end

   // Backing-store write port.
   always_ff @(posedge clk) begin
      if (wr_acc && wr_in_range) begin
         mem[wr_idx] <= w_data;
      end
   end

   // Read pipeline registers; busy is registered from the next-state valids
   // so it equals the OR of all stage valids including the output stage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pipe_valid <= '0;
         busy       <= 1'b0;
         for (int i = 0; i < int'(RD_LAT); i++) begin
            pipe_data[i] <= '0;
         end
      end else if (ce) begin
         pipe_valid   <= pipe_valid_nxt;
         busy         <= |pipe_valid_nxt;
         pipe_data[0] <= rd_word;
         for (int i = int'(RD_LAT) - 1; i > 0; i--) begin
            pipe_data[i] <= pipe_data[i-1];
         end
      end
   end

   assign r_data       = pipe_data[RD_LAT-1];
   assign r_data_valid = pipe_valid[RD_LAT-1];

   // Saturating request counters and sticky out-of-range flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_count <= '0;
         wr_count <= '0;
         oob_err  <= 1'b0;
      end else if (ce) begin
         if (rd_acc && (rd_count != '1)) begin
            rd_count <= rd_count + CNT_W'(1);
         end
         if (wr_acc && (wr_count != '1)) begin
            wr_count <= wr_count + CNT_W'(1);
         end
         if ((rd_acc && !rd_in_range) || (wr_acc && !wr_in_range)) begin
            oob_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ddr_channel_responder.sv
// ---------------------------------------------------------------------------
// tb_ddr_channel_responder
//
// Directed bench for ddr_channel_responder (RD_LAT=12, DEPTH_W=10). A table of
// per-cycle request records with hand-computed response data drives the main
// traffic; a response monitor checks data, order and arrival cycle. Clock
// enable, reset mid-flight and counter saturation use hand-written sequences.
// ---------------------------------------------------------------------------
module tb_ddr_channel_responder;

   localparam int unsigned ADDR_W  = 14;
   localparam int unsigned DW      = 512;
   localparam int unsigned DEPTH_W = 10;
   localparam int unsigned RD_LAT  = 12;

   logic              clk = 1'b0;
   logic              rst;
   logic              ce;
   logic              r_valid;
   logic [ADDR_W-1:0] r_addr;
   logic [DW-1:0]     r_data;
   logic              r_data_valid;
   logic              w_valid;
   logic [ADDR_W-1:0] w_addr;
   logic [DW-1:0]     w_data;
   logic              busy;
   logic [31:0]       rd_count;
   logic [31:0]       wr_count;
   logic              oob_err;

   ddr_channel_responder #(
      .ADDR_W    (ADDR_W),
      .OFFCHIP_DW(DW),
      .DEPTH_W   (DEPTH_W),
      .RD_LAT    (RD_LAT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ce          (ce),
      .r_valid     (r_valid),
      .r_addr      (r_addr),
      .r_data      (r_data),
      .r_data_valid(r_data_valid),
      .w_valid     (w_valid),
      .w_addr      (w_addr),
      .w_data      (w_data),
      .busy        (busy),
      .rd_count    (rd_count),
      .wr_count    (wr_count),
      .oob_err     (oob_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic              wv;
      logic [ADDR_W-1:0] wa;
      logic [DW-1:0]     wd;
      logic              rv;
      logic [ADDR_W-1:0] ra;
      logic [DW-1:0]     exp_rd;
   } vec_t;

   typedef struct {
      logic [DW-1:0] d;
      int            cyc;
   } resp_t;

   vec_t  vecs[$];
   resp_t exp_q[$];
   resp_t mon_e;
   int    checks = 0;
   int    errors = 0;
   int    cyc    = 0;
   bit    mon_en = 1'b0;

   function automatic logic [DW-1:0] rep(input logic [31:0] x);
      return {16{x}};
   endfunction

   function automatic vec_t mk(input logic wv, input logic [ADDR_W-1:0] wa,
                               input logic [DW-1:0] wd, input logic rv,
                               input logic [ADDR_W-1:0] ra, input logic [DW-1:0] ex);
      vec_t v;
      v.wv = wv; v.wa = wa; v.wd = wd; v.rv = rv; v.ra = ra; v.exp_rd = ex;
      return v;
   endfunction

   task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Applied at a negedge; the request is accepted at the next posedge and its
   // response is due at the negedge following posedge number cyc+RD_LAT.
   task automatic apply(input vec_t v);
      resp_t e;
      w_valid = v.wv; w_addr = v.wa; w_data = v.wd;
      r_valid = v.rv; r_addr = v.ra;
      if (v.rv) begin
         e.d   = v.exp_rd;
         e.cyc = cyc + int'(RD_LAT);
         exp_q.push_back(e);
      end
      @(negedge clk);
      w_valid = 1'b0;
      r_valid = 1'b0;
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Response monitor: order, data and arrival cycle.
   always @(negedge clk) begin
      if (mon_en && r_data_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_resp", DW'(r_data_valid), DW'(1'b0));
         end else begin
            mon_e = exp_q.pop_front();
            check("resp_data", r_data, mon_e.d);
            check("resp_cycle", DW'(cyc), DW'(mon_e.cyc));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int nresp;
      bit got;

      rst = 1'b1; ce = 1'b1;
      r_valid = 1'b0; r_addr = '0;
      w_valid = 1'b0; w_addr = '0; w_data = '0;

      // Table: phase A (rows 0..2) basic latency, phase B the rest.
      vecs.push_back(mk(1'b1, 14'h005, rep(32'hA5A5A5A5), 1'b0, 14'h000, '0));
      vecs.push_back(mk(1'b0, 14'h000, '0, 1'b0, 14'h000, '0));
      vecs.push_back(mk(1'b0, 14'h000, '0, 1'b1, 14'h005, rep(32'hA5A5A5A5)));
      // Collision: write-first forwarding.
      vecs.push_back(mk(1'b1, 14'h020, DW'(1), 1'b0, 14'h000, '0));
      vecs.push_back(mk(1'b1, 14'h020, DW'(2), 1'b1, 14'h020, DW'(2)));
      // Out-of-range write aliasing index 5 must be dropped.
      vecs.push_back(mk(1'b1, 14'h405, rep(32'hFFFFFFFF), 1'b0, 14'h000, '0));
      vecs.push_back(mk(1'b0, 14'h000, '0, 1'b1, 14'h400, '0));
      vecs.push_back(mk(1'b0, 14'h000, '0, 1'b1, 14'h005, rep(32'hA5A5A5A5)));
      // Streaming preload then back-to-back reads.
      for (int i = 0; i < 16; i++)
         vecs.push_back(mk(1'b1, 14'(i), DW'(i), 1'b0, 14'h000, '0));
      for (int i = 0; i < 16; i++)
         vecs.push_back(mk(1'b0, 14'h000, '0, 1'b1, 14'(i), DW'(i)));

      // Reset values.
      @(negedge clk);
      check("rst_r_data_valid", DW'(r_data_valid), DW'(1'b0));
      check("rst_r_data", r_data, '0);
      check("rst_busy", DW'(busy), DW'(1'b0));
      check("rst_rd_count", DW'(rd_count), DW'(32'd0));
      check("rst_wr_count", DW'(wr_count), DW'(32'd0));
      check("rst_oob_err", DW'(oob_err), DW'(1'b0));
      rst = 1'b0;
      mon_en = 1'b1;

      // Phase A: basic latency.
      for (int i = 0; i < 3; i++) apply(vecs[i]);
      repeat (RD_LAT + 2) @(negedge clk);
      check("basic_rd_count", DW'(rd_count), DW'(32'd1));
      check("basic_wr_count", DW'(wr_count), DW'(32'd1));
      check("basic_oob_err", DW'(oob_err), DW'(1'b0));
      check("basic_busy", DW'(busy), DW'(1'b0));
      check("basic_pending", DW'(exp_q.size()), DW'(0));

      // Phase B: collision, out-of-range, streaming.
      for (int i = 3; i < vecs.size(); i++) apply(vecs[i]);
      repeat (RD_LAT - 1) @(negedge clk);
      check("stream_last_valid", DW'(r_data_valid), DW'(1'b1));
      check("stream_last_data", r_data, DW'(15));
      check("stream_last_busy", DW'(busy), DW'(1'b1));
      @(negedge clk);
      check("stream_busy_low", DW'(busy), DW'(1'b0));
      check("stream_valid_low", DW'(r_data_valid), DW'(1'b0));
      check("b_rd_count", DW'(rd_count), DW'(32'd20));
      check("b_wr_count", DW'(wr_count), DW'(32'd20));
      check("b_oob_err", DW'(oob_err), DW'(1'b1));
      check("b_pending", DW'(exp_q.size()), DW'(0));
      mon_en = 1'b0;

      // Clock enable: 3 stalled edges mid-flight push the response out by 3.
      r_valid = 1'b1; r_addr = 14'd3;
      @(negedge clk);
      r_valid = 1'b0;
      got = 1'b0; lat = 0;
      if (r_data_valid) begin got = 1'b1; lat = 1; end
      for (int i = 2; i <= 25 && !got; i++) begin
         if (i == 5) begin
            ce = 1'b0;
            r_valid = 1'b1; r_addr = 14'd7;
            w_valid = 1'b1; w_addr = 14'd3; w_data = rep(32'hDEADBEEF);
         end
         @(negedge clk);
         if (r_data_valid) begin got = 1'b1; lat = i; end
         if (i == 7) begin
            check("ce_rd_frozen", DW'(rd_count), DW'(32'd21));
            check("ce_wr_frozen", DW'(wr_count), DW'(32'd20));
            ce = 1'b1; r_valid = 1'b0; w_valid = 1'b0;
         end
      end
      check("ce_latency", DW'(lat), DW'(15));
      check("ce_resp_data", r_data, DW'(3));
      ce = 1'b0;
      @(negedge clk);
      check("ce_hold_valid", DW'(r_data_valid), DW'(1'b1));
      check("ce_hold_data", r_data, DW'(3));
      check("ce_hold_rd_count", DW'(rd_count), DW'(32'd21));
      ce = 1'b1;
      @(negedge clk);
      check("ce_valid_drop", DW'(r_data_valid), DW'(1'b0));
      check("ce_busy_drop", DW'(busy), DW'(1'b0));

      // Reset mid-flight: 5 reads outstanding, asynchronous assertion.
      for (int a = 0; a < 5; a++) begin
         r_valid = 1'b1; r_addr = 14'(a);
         @(negedge clk);
      end
      r_valid = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("arst_valid", DW'(r_data_valid), DW'(1'b0));
      check("arst_data", r_data, '0);
      check("arst_busy", DW'(busy), DW'(1'b0));
      check("arst_rd_count", DW'(rd_count), DW'(32'd0));
      check("arst_wr_count", DW'(wr_count), DW'(32'd0));
      check("arst_oob_err", DW'(oob_err), DW'(1'b0));
      @(negedge clk);
      rst = 1'b0;
      nresp = 0;
      repeat (RD_LAT + 4) begin
         @(negedge clk);
         if (r_data_valid) nresp++;
      end
      check("no_resp_after_reset", DW'(nresp), DW'(0));
      // Store survives reset; the ce=0 write to addr 3 must not have landed.
      mon_en = 1'b1;
      apply(mk(1'b0, 14'h000, '0, 1'b1, 14'd3, DW'(3)));
      repeat (RD_LAT + 1) @(negedge clk);
      check("post_rst_pending", DW'(exp_q.size()), DW'(0));
      mon_en = 1'b0;
      check("post_rst_rd_count", DW'(rd_count), DW'(32'd1));
      check("post_rst_wr_count", DW'(wr_count), DW'(32'd0));

      // Saturation via backdoor preload of the read counter.
      force dut.rd_count = 32'hFFFF_FFFE;
      @(negedge clk);
      release dut.rd_count;
      check("sat_preload", DW'(rd_count), DW'(32'hFFFF_FFFE));
      for (int i = 0; i < 3; i++) begin
         r_valid = 1'b1; r_addr = 14'(i);
         @(negedge clk);
      end
      r_valid = 1'b0;
      check("sat_rd_count", DW'(rd_count), DW'(32'hFFFF_FFFF));
      check("sat_wr_count", DW'(wr_count), DW'(32'd0));
      repeat (RD_LAT + 2) @(negedge clk);
      check("sat_rd_hold", DW'(rd_count), DW'(32'hFFFF_FFFF));
      check("sat_busy", DW'(busy), DW'(1'b0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
